stream_fifo_flex: RTL
=====================

STREAM_FIFO_FLEX -- requirements
Module: stream_fifo_flex

Interface
REQ-001 SHALL have parameter DATA_TYPE, default logic [31:0], payload type carried by the FIFO.
REQ-002 SHALL have parameter FIFO_LEN, default 16, storage depth in entries; any integer >= 2, not only powers of two.
REQ-003 SHALL have parameter AF_THR, default FIFO_LEN-2, almost-full threshold in entries.
REQ-004 SHALL have parameter AE_THR, default 1, almost-empty threshold in entries.
REQ-005 SHALL have port ACLK  input  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port ARESET  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush_i  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have ports data_i (input, DATA_TYPE), valid_i (input, 1) and ready_o (output, 1), forming the write stream.
REQ-009 SHALL have ports data_o (output, DATA_TYPE), valid_o (output, 1) and ready_i (input, 1), forming the read stream.
REQ-010 SHALL have port level_o  output  LVL_W  occupancy in entries; LVL_W = $clog2(CAP+1), where CAP is the total capacity.
REQ-011 SHALL have ports almost_full_o and almost_empty_o, both output, 1 bit, threshold flags.

Function
REQ-012 SHALL define a write handshake as valid_i && ready_o, and a read handshake as valid_o && ready_i, each sampled at the rising edge of ACLK.
REQ-013 SHALL drive ready_o = (level_o != CAP) && !flush_i, with no combinational path from valid_i.
REQ-014 SHALL drive valid_o = (level_o != 0), with no combinational path from ready_i or valid_i.
REQ-015 SHALL present read data in strict write order, with no loss and no duplication.
REQ-016 SHALL assert valid_o with the written data one cycle after a write handshake into an empty FIFO; there is no same-cycle fall-through.
REQ-017 SHALL wrap the read and write pointers from FIFO_LEN-1 to 0 explicitly, so that non-power-of-two depths work.
REQ-018 SHALL handle a simultaneous read and write handshake by leaving level_o unchanged and advancing both pointers.
REQ-019 SHALL keep ready_o low when full, even if a read occurs in the same cycle; there is no pass-through at full.
REQ-020 SHALL give flush_i priority over both handshakes: on the next edge level_o=0, both pointers=0, and the read is not counted.
REQ-021 SHALL make level_o a register: +1 on a write only, -1 on a read only, otherwise held.
REQ-022 SHALL drive almost_full_o = (level_o >= AF_THR) and almost_empty_o = (level_o <= AE_THR), combinationally from the level_o register.
REQ-023 SHALL stop elaboration with $error unless FIFO_LEN >= 2, 1 <= AF_THR <= CAP and 0 <= AE_THR < AF_THR.

Reset
REQ-024 SHALL, while ARESET=1 at an edge, set pointers=0 and level_o=0; therefore valid_o=0, ready_o=0 during reset, almost_empty_o=1 and almost_full_o=0.
REQ-025 SHALL let reset override flush_i and all handshakes, and discard all contents when asserted mid-operation.
REQ-026 SHALL NOT reset the storage array, and SHALL drive data_o as don't-care while valid_o=0.

Configuration
REQ-027 SHALL honour macro STREAM_FIFO_FLEX_REG_OUT_EN, which controls the output register.
- Defined: data_o and valid_o come from a dedicated output register, and CAP=FIFO_LEN+1 (level_o counts the register).
- Defined: a write into an empty FIFO loads the output register directly, so the latency of REQ-016 is unchanged.
- Defined: flush_i and ARESET clear the output register's valid bit.
- Undefined: data_o is read asynchronously from storage at the read pointer, and CAP=FIFO_LEN.

Structure
REQ-028 SHALL take the level-width helper function (clog2 of N+1) from shared package stream_pkg.
REQ-029 SHALL take the stream handshake typedefs from the same shared package, stream_pkg.
REQ-030 SHALL instantiate storage as sub-module stream_fifo_mem: DATA_TYPE, DEPTH parameters, synchronous write, asynchronous read, no reset.
REQ-031 SHALL keep the pointer, level and flag logic and the output register in stream_fifo_flex itself.

Verification
REQ-032 SHALL cover: FIFO_LEN=5, ready_i=0, write 5 words 0x1..0x5 -> ready_o=0 after the 5th, level_o=5, almost_full_o=1 (AF_THR=3).
REQ-033 SHALL cover: continue REQ-032 with ready_i=1, valid_i=0 -> data_o reads 0x1..0x5 on consecutive cycles, pointers wrap, then valid_o=0, almost_empty_o=1.
REQ-034 SHALL cover: level_o=2, valid_i=1 and ready_i=1 together for 10 cycles -> level_o stays 2, and output order matches input.
REQ-035 SHALL cover: level_o=3, flush_i=1 together with valid_i=1 and ready_i=1 -> next cycle level_o=0, valid_o=0, and the written word is not stored.
REQ-036 SHALL cover: ARESET=1 for 1 cycle while full -> level_o=0, valid_o=0; after release, write 0xA -> valid_o=1 one cycle later with data_o=0xA.
REQ-037 SHALL cover: with STREAM_FIFO_FLEX_REG_OUT_EN defined and FIFO_LEN=4 -> 5 words accepted, level_o=5, and data_o changes only at clock edges.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream helpers: handshake typedefs and the level-width function
// used to size occupancy counters.
package stream_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } stream_hs_t;

  typedef enum logic [1:0] {
    HS_NONE = 2'b00,
    HS_WR   = 2'b01,
    HS_RD   = 2'b10,
    HS_BOTH = 2'b11
  } hs_e;

  function automatic int lvl_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic hs_e hs_kind(input stream_hs_t wr, input stream_hs_t rd);
    return hs_e'({rd.valid & rd.ready, wr.valid & wr.ready});
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module stream_fifo_mem #(
  parameter type DATA_TYPE = logic [31:0],
  parameter int  DEPTH     = 16,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  DATA_TYPE      wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output DATA_TYPE      rd_data_o
);

  DATA_TYPE mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_fifo_flex.sv
// Valid/ready stream FIFO with arbitrary depth and threshold flags.
// Macro STREAM_FIFO_FLEX_REG_OUT_EN adds an output register (capacity FIFO_LEN+1).
module stream_fifo_flex
  import stream_pkg::*;
#(
  parameter type DATA_TYPE = logic [31:0],
  parameter int  FIFO_LEN  = 16,
  parameter int  AF_THR    = FIFO_LEN - 2,
  parameter int  AE_THR    = 1,
`ifdef STREAM_FIFO_FLEX_REG_OUT_EN
  localparam int CAP       = FIFO_LEN + 1,
`else
  localparam int CAP       = FIFO_LEN,
`endif
  localparam int LVL_W     = lvl_width(CAP)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             flush_i,
  input  DATA_TYPE         data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output DATA_TYPE         data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LVL_W-1:0] level_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);

  localparam int PTR_W = (FIFO_LEN > 1) ? $clog2(FIFO_LEN) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_LEN - 1);
  localparam logic [LVL_W-1:0] CAP_L    = LVL_W'(CAP);
  localparam logic [LVL_W-1:0] AF_L     = LVL_W'(AF_THR);
  localparam logic [LVL_W-1:0] AE_L     = LVL_W'(AE_THR);

  if (FIFO_LEN < 2 || AF_THR < 1 || AF_THR > CAP || AE_THR < 0 || AE_THR >= AF_THR) begin : g_bad_params
    $error("stream_fifo_flex: illegal FIFO_LEN/AF_THR/AE_THR combination");
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  stream_hs_t       wr_port, rd_port;
  hs_e              hs;
  logic             wr_fire, rd_fire, mem_we;
  DATA_TYPE         mem_rd_data;

  assign ready_o = (level_q != CAP_L) && !flush_i && !ARESET;
  assign wr_port = '{valid: valid_i, ready: ready_o};
  assign rd_port = '{valid: valid_o, ready: ready_i};
  assign hs      = hs_kind(wr_port, rd_port);
  assign wr_fire = (hs == HS_WR) || (hs == HS_BOTH);
  assign rd_fire = (hs == HS_RD) || (hs == HS_BOTH);

  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= AF_L);
  assign almost_empty_o = (level_q <= AE_L);

  always_comb begin
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else begin
      case (hs)
        HS_WR:   level_d = level_q + LVL_W'(1);
        HS_RD:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

`ifdef STREAM_FIFO_FLEX_REG_OUT_EN
  logic     out_valid_q, out_valid_d;
  DATA_TYPE out_data_q, out_data_d;
  logic     mem_empty, out_free;

  // The output register counts toward level, so storage is empty when only it is held.
  assign mem_empty = (level_q == LVL_W'(out_valid_q));
  assign out_free  = !out_valid_q || rd_fire;
  assign valid_o   = out_valid_q;
  assign data_o    = out_data_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_we      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_free) begin
        if (!mem_empty) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_rd_data;
          rd_ptr_d    = next_ptr(rd_ptr_q);
        end else if (wr_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = data_i;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      if (wr_fire && !(out_free && mem_empty)) begin
        mem_we   = 1'b1;
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) out_valid_q <= 1'b0;
    else        out_valid_q <= out_valid_d;
  end

  always_ff @(posedge ACLK) begin
    out_data_q <= out_data_d;
  end
`else
  assign valid_o = (level_q != '0);
  assign data_o  = mem_rd_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_we   = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) begin
        mem_we   = 1'b1;
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (rd_fire) rd_ptr_d = next_ptr(rd_ptr_q);
    end
  end
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  stream_fifo_mem #(
    .DATA_TYPE (DATA_TYPE),
    .DEPTH     (FIFO_LEN)
  ) u_mem (
    .clk       (ACLK),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

endmodule
